// File: rtl/boot_ctrl_pkg.sv
// Shared types and constants for the boot sequencer.
package boot_ctrl_pkg;

   typedef enum logic [2:0] {
      SYNC,
      LEN,
      DATA,
      WRITE,
      CSUM,
      DONE,
      ERR
   } state_t;

   localparam logic [7:0] SYNC_BYTE  = 8'hA5;
   localparam int         BYTE_IDX_W = 2;

endpackage

// File: rtl/boot_ctrl.sv
// Boot sequencer: receives a framed image over a byte stream, writes it into
// instruction memory and releases the core once the checksum matches.
//
// state | meaning
// SYNC  | discard bytes until the sync byte arrives
// LEN   | collect 4-byte little-endian word count
// DATA  | collect 4 payload bytes of one word
// WRITE | one-cycle memory write bubble, then next word or checksum
// CSUM  | compare one byte against the running XOR of the payload
// DONE  | image verified, core released (left only by reset)
// ERR   | load aborted, core held (left only by reset)
module boot_ctrl
   import boot_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int TIMEOUT    = 1000000
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [7:0]            rx_data_i,
   input  logic                  rx_valid_i,
   output logic                  rx_ready_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [31:0]           mem_data_o,
   output logic                  mem_we_o,
   output logic [3:0]            mem_be_o,
   output logic                  core_rst_no,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);

   // Down-counter: loaded on accept/state entry, expiry when it sits at zero
   // on an idle cycle, so the abort lands after TIMEOUT-1 idle cycles.
   localparam int                TMR_W     = $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(TIMEOUT - 2);
   localparam logic [32:0]       MAX_WORDS = 33'd1 << ADDR_WIDTH;

   state_t                  state_q, state_d;
   logic [BYTE_IDX_W-1:0]   idx_q, idx_d;
   logic [23:0]             len_q, len_d;
   logic [ADDR_WIDTH:0]     rem_q, rem_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [31:0]             data_q, data_d;
   logic [7:0]              csum_q, csum_d;
   logic [TMR_W-1:0]        tmr_q, tmr_d;
   logic                    we_q, we_d;
   logic [3:0]              be_q, be_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic                    accept;
   logic                    tmr_zero;
   logic [31:0]             len_word;

   assign rx_ready_o = !rst_i && (state_q inside {SYNC, LEN, DATA, CSUM});
   assign accept     = rx_valid_i && rx_ready_o;
   assign tmr_zero   = (tmr_q == '0);
   assign len_word   = {rx_data_i, len_q};

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      rem_d   = rem_q;
      addr_d  = addr_q;
      data_d  = data_q;
      csum_d  = csum_q;
      tmr_d   = tmr_q;

      if (state_q inside {LEN, DATA, CSUM}) begin
         tmr_d = accept ? TMR_LOAD : tmr_q - TMR_W'(1);
      end

      case (state_q)
         SYNC: begin
            if (accept && rx_data_i == SYNC_BYTE) begin
               state_d = LEN;
               idx_d   = '0;
               len_d   = '0;
               csum_d  = '0;
               addr_d  = '0;
               tmr_d   = TMR_LOAD;
            end
         end
         LEN: begin
            if (accept) begin
               len_d = {rx_data_i, len_q[23:8]};
               idx_d = idx_q + BYTE_IDX_W'(1);
               if (idx_q == '1) begin
                  if ({1'b0, len_word} > MAX_WORDS) begin
                     state_d = ERR;
                  end else if (len_word == '0) begin
                     state_d = CSUM;
                  end else begin
                     state_d = DATA;
                     rem_d   = len_word[ADDR_WIDTH:0];
                  end
               end
            end else if (tmr_zero) begin
               state_d = ERR;
            end
         end
         DATA: begin
            if (accept) begin
               data_d = {rx_data_i, data_q[31:8]};
               csum_d = csum_q ^ rx_data_i;
               idx_d  = idx_q + BYTE_IDX_W'(1);
               if (idx_q == '1) begin
                  state_d = WRITE;
               end
            end else if (tmr_zero) begin
               state_d = ERR;
            end
         end
         WRITE: begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            rem_d   = rem_q - (ADDR_WIDTH + 1)'(1);
            idx_d   = '0;
            tmr_d   = TMR_LOAD;
            state_d = (rem_q == (ADDR_WIDTH + 1)'(1)) ? CSUM : DATA;
         end
         CSUM: begin
            if (accept) begin
               state_d = (rx_data_i == csum_q) ? DONE : ERR;
            end else if (tmr_zero) begin
               state_d = ERR;
            end
         end
         default: ;
      endcase

      we_d   = (state_d == WRITE);
      be_d   = we_d ? 4'hF : 4'h0;
      busy_d = state_d inside {LEN, DATA, WRITE, CSUM};
      done_d = (state_d == DONE);
      err_d  = (state_d == ERR);
   end

   // State and output registers; memory contents are outside and untouched by reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= SYNC;
         idx_q   <= '0;
         len_q   <= '0;
         rem_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         csum_q  <= '0;
         tmr_q   <= '0;
         we_q    <= 1'b0;
         be_q    <= 4'h0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         rem_q   <= rem_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         csum_q  <= csum_d;
         tmr_q   <= tmr_d;
         we_q    <= we_d;
         be_q    <= be_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign mem_addr_o  = addr_q;
   assign mem_data_o  = data_q;
   assign mem_we_o    = we_q;
   assign mem_be_o    = be_q;
   assign core_rst_no = done_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;

endmodule
